// File: rtl/multiword_add_sequencer.sv
// Streaming multi-word adder: one n-bit word pair per beat, LS word first, with the
// inter-word carry registered and one registered result word per accepted beat.

module Data_Flow_Ripple_Adder #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[n];
endmodule

module multiword_add_sequencer #(
    parameter int unsigned n     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [n-1:0]               in_a,
    input  logic [n-1:0]               in_b,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [n-1:0]               out_sum,
    output logic [$clog2(WORDS)-1:0]   out_idx,
    output logic                       out_last,
    output logic                       out_carry,
    output logic                       out_ovf,
    output logic                       busy
);
    localparam int unsigned IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [IW-1:0] word_idx_q, word_idx_d;
    logic          carry_q, carry_d;
    logic          out_valid_q, out_valid_d;
    logic [n-1:0]  out_sum_q, out_sum_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          out_carry_q, out_carry_d;
    logic          out_ovf_q, out_ovf_d;

    logic          accept;
    logic          is_last;
    logic          add_cin;
    logic [n-1:0]  add_sum;
    logic          add_cout;

    // Word 0 always starts from the fresh operation carry-in, never from carry_q.
    assign add_cin = (word_idx_q == '0) ? in_cin : carry_q;

    Data_Flow_Ripple_Adder #(.n(n)) u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        is_last     = (word_idx_q == LAST_IDX);

        word_idx_d  = word_idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            word_idx_d  = '0;
            carry_d     = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_idx_d   = word_idx_q;
            out_last_d  = is_last;
            out_carry_d = is_last ? add_cout : 1'b0;
            out_ovf_d   = is_last ? ((in_a[n-1] == in_b[n-1]) && (add_sum[n-1] != in_a[n-1])) : 1'b0;
            carry_d     = is_last ? 1'b0 : add_cout;
            word_idx_d  = is_last ? '0 : word_idx_q + IW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q  <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            word_idx_q  <= word_idx_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (word_idx_q != '0);
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Streaming front-end for the team's `Data_Flow_Ripple_Adder` (instantiated with `n` = word width). It adds two `WORDS`×`n`-bit operands that arrive one `n`-bit word per beat, least-significant word first, over a valid/ready handshake. It registers the inter-word carry so that each beat's carry-in is the previous beat's carry-out, and emits one sum word per accepted beat through a single-entry registered output stage. On the last word it also reports final carry and signed overflow.

## Interface
- `n`, 8: word width in bits, ≥ 2; passed to the ripple adder.
- `WORDS`, 4: words per operation, ≥ 2; the word counter is `$clog2(WORDS)` bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset: one clock; reset is asynchronous and active-low.
- `clear`  input  1  synchronous abort. Discards the operation in progress and any held output.
- `in_valid`  input  1  an operand word pair is present.
- `in_ready`  output  1  the block can accept a beat this cycle.
- `in_a`, `in_b`  input  n  operand words, LS word first.
- `in_cin`  input  1  operation carry-in. Sampled only on word 0.
- `out_valid`  output  1  `out_*` holds a result word.
- `out_ready`  input  1  the consumer takes the result this cycle.
- `out_sum`  output  n  sum word.
- `out_idx`  output  `$clog2(WORDS)`  index of `out_sum` within the operation.
- `out_last`  output  1  `out_sum` is word `WORDS-1`.
- `out_carry`  output  1  final carry-out. Meaningful only when `out_last`=1, otherwise 0.
- `out_ovf`  output  1  signed overflow of the full-width sum. Meaningful only when `out_last`=1, otherwise 0.
- `busy`  output  1  at least one word of the current operation has been accepted.

## Operation
- Accept rule: accept = `in_valid && in_ready`, where `in_ready = !out_valid || out_ready` (combinational from `out_ready`, no bubble).
- State is held in `word_idx` (0..WORDS-1) and `carry_q`.
  - IDLE: `word_idx` = 0.
  - BUSY: `word_idx` ≠ 0.
- Adder carry-in: `in_cin` when `word_idx` = 0, otherwise `carry_q`.
- On accept:
  - `out_sum` ← adder sum.
  - `out_idx` ← `word_idx`.
  - `out_last` ← (`word_idx` = WORDS-1).
  - `carry_q` ← adder carry.
  - `word_idx` ← `word_idx`+1, wrapping to 0 after WORDS-1.
- Last word only:
  - `out_carry` ← adder carry.
  - `out_ovf` ← (`in_a[n-1]` = `in_b[n-1]`) && (sum[n-1] ≠ `in_a[n-1]`).
  - `carry_q` ← 0.
- `out_valid`:
  - Set on accept.
  - Cleared when `out_ready` is high and there is no accept in the same cycle.
  - Accept and consume in the same cycle keeps it 1 and loads the new word.
- `busy` = (`word_idx` ≠ 0).
- `out_*` hold stable while `out_valid && !out_ready`.
- `clear` has priority over accept. It zeroes `word_idx`, `carry_q` and `out_valid`; `in_ready` follows from `out_valid` (1 the cycle after `clear`).
- Arithmetic is modulo 2^n per word. The full result is WORDS·n bits plus `out_carry`.
- Gaps (`in_valid` low) between words of one operation are legal; state holds.

## Timing
- Reset values: `out_valid`=0, `out_sum`=0, `out_idx`=0, `out_last`=0, `out_carry`=0, `out_ovf`=0, `busy`=0, `word_idx`=0, `carry_q`=0, `in_ready`=1.
- Reset asserted mid-operation aborts immediately; there is no partial output after deassertion.
- Latency: a word accepted at edge k is on `out_*` with `out_valid`=1 from edge k until consumed.
- Throughput: one word per cycle while `out_ready`=1. A full operation takes WORDS cycles minimum.
- Back-to-back operations: word 0 of the next operation may be accepted the cycle after the last word. `in_cin` applies fresh; stale carry is never used.
- Backpressure: `out_ready`=0 with `out_valid`=1 forces `in_ready`=0 and freezes `word_idx` and `carry_q`.
- The combinational path is `in_a`/`in_b` → n-stage ripple → output register. There is no path from `in_*` to any output within the same cycle. `out_ready` → `in_ready` is the only combinational path.

## Test plan
All cases use n=8, WORDS=4. Word lists are LS word first.
- Carry chain: A=0x00FFFFFF, B=0x00000001, cin=0, `out_ready`=1. Required: `out_sum` 00,00,00,01; `out_idx` 0..3; `out_last` only on idx 3; `out_carry`=0, `out_ovf`=0; 4 cycles.
- Signed overflow: A=0x7FFFFFFF, B=1, cin=0. Required: sums 00,00,00,80; last word `out_carry`=0, `out_ovf`=1.
- Carry-out via cin: A=0xFFFFFFFF, B=0, cin=1. Required: sums 00,00,00,00; `out_carry`=1, `out_ovf`=0. A back-to-back next operation A=B=0, cin=0 must yield all zeros with `out_carry`=0, proving no stale carry.
- Backpressure: drop `out_ready` for 3 cycles after word 1. Required: `in_ready`=0, `out_sum`/`out_idx` stable and `busy`=1 throughout; the final result equals the unstalled result.
- `clear` after word 2: `out_valid`=0 and `busy`=0 next cycle. A following operation A=0x00000002, B=0x00000003 yields 05,00,00,00.
- Async reset: assert `rst_n` low mid-operation, between clock edges. All outputs go to reset values immediately; the next operation after release computes correctly from word 0.
